// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clk out on X, gapless between words.
// Latency 0: the first bit is on X at the accepting edge. din_ready is high in IDLE and during a frame's last bit.
// Optional SER_PARITY_EN appends an even-parity bit after the data bits, so a frame is WIDTH+1 bits long.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             X,
    output logic             x_valid,
    output logic             frame_done
);
`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = $clog2(FL);
    localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             accept;
    logic             last_bit;
    logic             advance;
`ifdef SER_PARITY_EN
    logic             parity;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_nxt = state;
        last_bit  = (state == SHIFT) && (bit_cnt == LAST_IDX);
        din_ready = rst_n && ((state == IDLE) || last_bit);
        accept    = din_valid && din_ready;
        advance   = (state == SHIFT) && !last_bit;
        cnt_nxt   = bit_cnt + 1'b1;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bit_cnt indexes the bit currently on X; sreg holds the bits not yet driven.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            X          <= IDLE_LEVEL;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            sreg       <= '0;
`ifdef SER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                X          <= head(din);
                sreg       <= drop_head(din);
                bit_cnt    <= '0;
                x_valid    <= 1'b1;
                frame_done <= 1'b0;
`ifdef SER_PARITY_EN
                parity     <= ^din;
`endif
            end else if (advance) begin
                bit_cnt    <= cnt_nxt;
                frame_done <= (cnt_nxt == LAST_IDX);
`ifdef SER_PARITY_EN
                if (cnt_nxt == CW'(WIDTH)) begin
                    X <= parity;
                end else begin
                    X    <= head(sreg);
                    sreg <= drop_head(sreg);
                end
`else
                X    <= head(sreg);
                sreg <= drop_head(sreg);
`endif
            end else begin
                X          <= IDLE_LEVEL;
                x_valid    <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share stimulus and are checked
// every cycle against a queue-of-pending-bits reference model.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = '0;
    logic       rdy_m, rdy_l, x_m, x_l, xv_m, xv_l, fd_m, fd_l;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .X(x_m), .x_valid(xv_m), .frame_done(fd_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .X(x_l), .x_valid(xv_l), .frame_done(fd_l)
    );

    typedef struct packed {
        logic m;
        logic l;
        logic last;
    } bit_t;

    bit_t       pend[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] obs, exp_v;
    logic       acc;

    // One clock: drive inputs, predict from the pending-bit queue, and capture
    // {rdy_m, rdy_l, x_m, x_l, xv_m, xv_l, fd_m, fd_l} into obs / exp_v.
    task automatic step(input logic v, input logic [7:0] w, input logic r);
        bit_t b;
        logic er, em, el, ev, ef;
        @(negedge clk);
        din_valid = v;
        din       = w;
        rst_n     = r;
        #1;
        er = r && (pend.size() == 0);
        obs[7:6] = {rdy_m, rdy_l};
        acc = v && er;
        @(posedge clk);
        em = 1'b0; el = 1'b0; ev = 1'b0; ef = 1'b0;
        if (!r) begin
            pend.delete();
        end else begin
            if (acc) begin
                for (int i = 0; i < FL; i++) begin
                    if (i < W) begin
                        b.m = w[W-1-i];
                        b.l = w[i];
                    end else begin
                        b.m = ^w;
                        b.l = ^w;
                    end
                    b.last = (i == FL - 1);
                    pend.push_back(b);
                end
            end
            if (pend.size() > 0) begin
                b  = pend.pop_front();
                em = b.m; el = b.l; ev = 1'b1; ef = b.last;
            end
        end
        #1;
        obs[5:0] = {x_m, x_l, xv_m, xv_l, fd_m, fd_l};
        exp_v    = {er, er, em, el, ev, ev, ef, ef};
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'($urandom), 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset cyc%0d got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] got_m = '0;
        step(1'b1, 8'b0010_1001, 1'b1);
        for (int k = 0; k < FL + 3; k++) begin
            if (k > 0) step(1'b0, 8'h00, 1'b1);
            if (k < 8) got_m = {got_m[6:0], x_m};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single cyc%0d got %b want %b", k, obs, exp_v);
            end
        end
        checks++;
        if (got_m !== 8'b0010_1001) begin
            errors++;
            $display("FAIL single_stream got %b want 00101001", got_m);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] got_l = '0;
        logic [7:0] got_m = '0;
        step(1'b1, 8'h01, 1'b1);
        for (int k = 0; k < FL + 2; k++) begin
            if (k > 0) step(1'b0, 8'h00, 1'b1);
            if (k < 8) begin
                got_l = {got_l[6:0], x_l};
                got_m = {got_m[6:0], x_m};
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL lsb cyc%0d got %b want %b", k, obs, exp_v);
            end
        end
        checks++;
        if ({got_l, got_m} !== 16'b1000_0000_0000_0001) begin
            errors++;
            $display("FAIL lsb_stream got %b want 1000000000000001", {got_l, got_m});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws[2];
        logic [17:0] stream = '0;
        logic [17:0] want;
        int sent = 0;
        int first = -1;
        int last_hi = -1;
        ws[0] = 8'hA5;
        ws[1] = 8'h3C;
`ifdef SER_PARITY_EN
        want = {8'hA5, 1'b0, 8'h3C, 1'b0};
`else
        want = {2'b00, 16'hA53C};
`endif
        for (int k = 0; k < 40; k++) begin
            if (sent < 2) step(1'b1, ws[sent], 1'b1);
            else          step(1'b0, 8'h00, 1'b1);
            if (acc) sent++;
            if (xv_m) begin
                stream = {stream[16:0], x_m};
                if (first < 0) first = k;
                last_hi = k;
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc%0d got %b want %b", k, obs, exp_v);
            end
        end
        checks++;
        if (stream !== want || (last_hi - first + 1) !== 2 * FL) begin
            errors++;
            $display("FAIL b2b_stream got %b span %0d want %b span %0d",
                     stream, last_hi - first + 1, want, 2 * FL);
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2)      step(1'b0, 8'h00, 1'b0);
            else if (k > 0)  step(1'b0, 8'h00, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL midreset cyc%0d got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic v = 1'b0;
        logic r;
        logic [7:0] cur = '0;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) != 0);
            if (!v && $urandom_range(0, 2) != 0) begin
                v   = 1'b1;
                cur = 8'($urandom);
            end
            step(v, cur, r);
            if (acc) v = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d din %h got %b want %b", k, cur, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
